// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the decode stage, the immediate generator and
// the execute stage. The slave side is the immediate generator itself.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [24:0]       in_imm;
    logic [2:0]        in_src;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_imm, in_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the RV immediate formats (plus the
// CSR zero-extended uimm) from instruction bits [31:7] and queues the
// XLEN-wide result, with its tag and an illegal-select flag, in a small
// DEPTH-entry FIFO between decode and execute.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    imm_gen_pipe_if.slave          bus,
    output logic                   illegal_seen,
    output logic [$clog2(DEPTH):0] occupancy
);

    // A single-entry buffer still needs a one-bit pointer to index the array.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:7]      instr;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm_ext;
    logic             err_in;

    logic [XLEN-1:0]  mem_imm [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic             mem_err [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0]  last_imm;
    logic [TAG_W-1:0] last_tag;
    logic             last_err;

    logic             push;
    logic             pop;

    // Pointers wrap explicitly so non-trivial DEPTH=1 sizing still works.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign instr = bus.in_imm;
    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = bus.out_valid && bus.out_ready;

    // Decode the selected format into a 32-bit signed value, then widen it.
    always_comb begin
        imm32  = '0;
        err_in = 1'b0;
        case (bus.in_src)
            3'd0: imm32 = {{20{instr[31]}}, instr[31:20]};
            3'd1: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd2: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
            3'd3: imm32 = {instr[31:12], 12'b0};
            3'd4: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
            3'd5: imm32 = {27'b0, instr[19:15]};
            default: err_in = 1'b1;
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    // Buffer storage; only written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_imm[wr_ptr] <= imm_ext;
            mem_tag[wr_ptr] <= bus.in_tag;
            mem_err[wr_ptr] <= err_in;
        end
    end

    // Pointer, occupancy, sticky flag and last-popped head bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            illegal_seen <= 1'b0;
            last_imm     <= '0;
            last_tag     <= '0;
            last_err     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
                if (err_in) begin
                    illegal_seen <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr   <= next_ptr(rd_ptr);
                last_imm <= mem_imm[rd_ptr];
                last_tag <= mem_tag[rd_ptr];
                last_err <= mem_err[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head presentation; an empty buffer keeps showing the last popped entry.
    always_comb begin
        bus.out_valid = (count != '0);
        bus.in_ready  = (count < CNT_W'(DEPTH));
        bus.out_imm   = bus.out_valid ? mem_imm[rd_ptr] : last_imm;
        bus.out_tag   = bus.out_valid ? mem_tag[rd_ptr] : last_tag;
        bus.out_err   = bus.out_valid ? mem_err[rd_ptr] : last_err;
        occupancy     = count;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe (XLEN=64, DEPTH=2): directed RV
// encodings, backpressure, illegal selects, mid-operation reset and a
// randomized traffic phase checked against an arithmetic reference model.
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    typedef struct {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic clk;
    logic rst;
    logic illegal_seen;
    logic [$clog2(DEPTH):0] occupancy;

    imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .illegal_seen (illegal_seen),
        .occupancy    (occupancy)
    );

    exp_t q[$];
    bit   model_illegal;
    bit   mon_en;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint field(input bit [31:0] x, input int hi, input int lo);
        return longint'((x >> lo) & ((32'd1 << (hi - lo + 1)) - 1));
    endfunction

    // Reference: rebuild the 32-bit instruction and evaluate each format
    // numerically (sign as a negative weight, fields as scaled values).
    function automatic logic [XLEN-1:0] ref_imm(input logic [24:0] f, input logic [2:0] s);
        bit [31:0] ins;
        int signed si;
        longint w;
        longint v;
        ins = {f, 7'b0};
        si  = ins;
        w   = si;
        case (s)
            3'd0: v = w >>> 20;
            3'd1: v = (w >>> 25) * 32 + field(ins, 11, 7);
            3'd2: v = (ins[31] ? -64'sd4096 : 64'sd0) + field(ins, 7, 7) * 2048
                      + field(ins, 30, 25) * 32 + field(ins, 11, 8) * 2;
            3'd3: v = (w >>> 12) * 4096;
            3'd4: v = (ins[31] ? -64'sd1048576 : 64'sd0) + field(ins, 19, 12) * 4096
                      + field(ins, 20, 20) * 2048 + field(ins, 30, 21) * 2;
            3'd5: v = field(ins, 19, 15);
            default: v = 0;
        endcase
        return v[XLEN-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one instruction and hold it until accepted; waited = refused edges.
    task automatic applyStimulus(input logic [24:0] imm, input logic [2:0] src,
                                 input logic [TAG_W-1:0] tag, output int waited);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_imm   = imm;
        bus.in_src   = src;
        bus.in_tag   = tag;
        waited       = 0;
        acc          = 1'b0;
        while (!acc && waited < 20) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        if (!acc) checkOutput("accept_timeout", 64'(waited), 64'd0);
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard producer: record every accepted entry, discard all on reset.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            model_illegal = 1'b0;
        end else if (bus.in_valid && bus.in_ready) begin
            exp_t e;
            e.imm = ref_imm(bus.in_imm, bus.in_src);
            e.tag = bus.in_tag;
            e.err = (bus.in_src >= 3'd6);
            q.push_back(e);
            if (e.err) model_illegal = 1'b1;
        end
    end

    // Monitor: status against the model, and head contents on each pop.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("occupancy", 64'(occupancy), 64'(q.size()));
            checkOutput("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
            checkOutput("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            checkOutput("illegal_seen", 64'(illegal_seen), 64'(model_illegal));
            if (bus.out_valid && bus.out_ready && !rst) begin
                if (q.size() == 0) begin
                    checkOutput("pop_underflow", 64'(bus.out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checkOutput("out_imm", 64'(bus.out_imm), 64'(e.imm));
                    checkOutput("out_tag", 64'(bus.out_tag), 64'(e.tag));
                    checkOutput("out_err", 64'(bus.out_err), 64'(e.err));
                end
            end
        end
    end

    // Directed head check right after an accept into an empty buffer.
    task automatic directed(input string name, input logic [24:0] imm, input logic [2:0] src,
                            input logic [TAG_W-1:0] tag, input logic [63:0] exp_imm,
                            input logic exp_err);
        int w;
        applyStimulus(imm, src, tag, w);
        checkOutput({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        checkOutput({name, "_imm"}, 64'(bus.out_imm), exp_imm);
        checkOutput({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        checkOutput({name, "_err"}, 64'(bus.out_err), 64'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int n;
        checks        = 0;
        errors        = 0;
        mon_en        = 1'b0;
        model_illegal = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_src    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("rst_illegal", 64'(illegal_seen), 64'd0);
        checkOutput("rst_out_imm", 64'(bus.out_imm), 64'd0);
        checkOutput("rst_out_tag", 64'(bus.out_tag), 64'd0);
        checkOutput("rst_out_err", 64'(bus.out_err), 64'd0);
        mon_en = 1'b1;

        bus.out_ready = 1'b1;
        directed("addi", 25'h1FFE001, 3'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        directed("beq",  25'h1FC001D, 3'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        directed("sfmt", 25'h1FC001D, 3'd1, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        directed("lui",  25'h1000001, 3'd3, 5'd4, 64'hFFFF_FFFF_8000_0000, 1'b0);
        directed("zimm", 25'h1000001, 3'd5, 5'd5, 64'h0, 1'b0);
        directed("ill6", 25'h1ABCDEF, 3'd6, 5'd7, 64'h0, 1'b1);
        checkOutput("illegal_set", 64'(illegal_seen), 64'd1);
        directed("jal",  25'h1ABCDEF, 3'd4, 5'd8, 64'(ref_imm(25'h1ABCDEF, 3'd4)), 1'b0);
        checkOutput("illegal_sticky", 64'(illegal_seen), 64'd1);

        // Backpressure: fill, hold a third entry off, then release.
        bus.out_ready = 1'b0;
        applyStimulus(25'h0123456, 3'd0, 5'd10, w);
        applyStimulus(25'h0654321, 3'd4, 5'd11, w);
        checkOutput("bp_full_occ", 64'(occupancy), 64'd2);
        checkOutput("bp_full_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_imm   = 25'h1555555;
        bus.in_src   = 3'd2;
        bus.in_tag   = 5'd12;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bp_held_occ", 64'(occupancy), 64'd2);
        bus.out_ready = 1'b1;
        applyStimulus(25'h1555555, 3'd2, 5'd12, w);
        checkOutput("bp_third_wait", 64'(w), 64'd1);
        n = 0;
        while (occupancy != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("bp_drained", 64'(occupancy), 64'd0);

        // Reset with two buffered entries and a pending input.
        bus.out_ready = 1'b0;
        applyStimulus(25'h0F0F0F0, 3'd1, 5'd20, w);
        applyStimulus(25'h0A0A0A0, 3'd3, 5'd21, w);
        checkOutput("pre_rst_occ", 64'(occupancy), 64'd2);
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid_rst_occ", 64'(occupancy), 64'd0);
        checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("mid_rst_illegal", 64'(illegal_seen), 64'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_occ", 64'(occupancy), 64'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_imm    = 25'($urandom);
            bus.in_src    = 3'($urandom_range(0, 7));
            bus.in_tag    = TAG_W'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            rst           = ($urandom_range(0, 79) == 0);
            @(posedge clk);
            #1;
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("final_drain", 64'(q.size()), 64'd0);
        @(negedge clk);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the next-generation core.
- Takes instruction bits [31:7] plus an immediate-type select, and produces the XLEN-wide extended immediate.
- Covers all RV base formats plus the CSR zero-extended uimm, for XLEN 32 or 64.
- Output is registered into a DEPTH-entry buffer with valid/ready handshakes on both sides, so it can sit between the decode and execute stages of the pipelined/multi-cycle core.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 2, output buffer entries; power of 2, at least 1.
- TAG_W, 5, width of the sideband tag carried alongside each immediate (typically rd).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  block can accept this cycle.
- in_imm  input  25  instruction bits [31:7]; in_imm[k] = instr[k+7].
- in_src  input  3  immediate type: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z, 6/7=illegal.
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  output  1  buffer head is valid.
- out_ready  input  1  downstream accepts the head.
- out_imm  output  XLEN  extended immediate at the buffer head.
- out_tag  output  TAG_W  tag at the buffer head.
- out_err  output  1  head entry came from an illegal in_src.
- illegal_seen  output  1  sticky flag; set by any accepted illegal in_src, cleared only by rst.
- occupancy  output  clog2(DEPTH)+1  number of valid buffer entries.

Behaviour:
- Accept: an entry is accepted when in_valid && in_ready at a rising edge.
- Pop: the head is popped when out_valid && out_ready at a rising edge.
- Input ready: in_ready = (occupancy < DEPTH). It is registered-state derived only; there is no combinational path from out_ready.
- Latency: an entry accepted at edge N appears at the head (out_valid=1) after edge N, provided the buffer was empty. Entries are delivered strictly in acceptance order.
- Simultaneous push and pop:
  - Both happen in the same edge; occupancy is unchanged and the pointers advance.
  - When full, in_ready=0, so no push occurs even if out_ready=1 that cycle.
- Pointers: read and write pointers wrap modulo DEPTH.
- Empty outputs: when empty, out_valid=0 and out_imm/out_tag/out_err hold their last value. Benches must not check them while out_valid=0.
- Extension rules, written in instr[] indices, with sext/zext to XLEN:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: sext({instr[31:12], 12'b0}). Upper bits replicate instr[31] when XLEN=64.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Z: zext(instr[19:15]).
  - Illegal (6/7): the entry is still pushed with imm=0 and err=1, and illegal_seen is set after that edge.
- Extension is computed combinationally from the inputs and written into the buffer at acceptance.
- Reset values: occupancy=0, out_valid=0, in_ready=1, illegal_seen=0, out_imm=0, out_tag=0, out_err=0, pointers=0.
- Reset mid-operation: rst asserted at any edge discards all entries, including any same-cycle push or pop. It has priority over every other event.
- DEPTH=1: in_ready=!out_valid, so the block behaves as a half-rate register slice. Throughput is 1 entry per 2 cycles under continuous flow.
- DEPTH>=2: full throughput of 1 entry per cycle when out_ready is held at 1.

Test Plan:
- addi x1,x0,-1 (instr 0xFFF00093): in_imm=0x1FFE001, src=0, tag=1, out_ready=1 -> out_valid the next cycle; out_imm=0xFFFFFFFF (XLEN=32), out_tag=1, out_err=0.
- beq x0,x0,-4 (instr 0xFE000EE3): in_imm=0x1FC001D, src=2 -> out_imm=0xFFFFFFFC. Same in_imm with src=1 -> 0xFFFFFFFD.
- lui x1,0x80000 (instr 0x800000B7): in_imm=0x1000001, src=3, XLEN=64 -> out_imm=0xFFFFFFFF80000000. Same in_imm with src=5 -> 0x0.
- Backpressure, DEPTH=2: push 3 entries with out_ready=0 -> in_ready drops after 2 accepts; occupancy=2; third entry held off. Raise out_ready -> entries drain in order; third is accepted the cycle after the first pop.
- Illegal src=6 with tag=7 -> out_imm=0, out_err=1, illegal_seen=1. illegal_seen stays 1 through later legal traffic until rst.
- Assert rst for one cycle with 2 entries buffered and in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, illegal_seen=0; the pending input is not stored.
